// File: rtl/image_ingest.sv
// rtl/image_ingest.sv - ping-pong 16x16 frame assembler between host pixel stream and conv front end
module image_ingest #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_last,
    output logic              frame_valid,
    output logic              frame_start,
    input  logic              frame_done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic [7:0]        frame_count,
    output logic              err_frame
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] wr_ptr;
    logic              wbank;
    logic              rbank;
    logic [PIX_W-1:0]  bank0 [DEPTH];
    logic [PIX_W-1:0]  bank1 [DEPTH];

    logic accept;
    logic ptr_at_end;
    logic complete;
    logic short_frame;
    logic swap;
    logic release_rd;

    // The read bank is always the one the host is not filling.
    assign rbank       = ~wbank;
    assign accept      = s_valid && (state == FILL);
    assign ptr_at_end  = (wr_ptr == {ADDR_W{1'b1}});
    assign complete    = accept && ptr_at_end;
    assign short_frame = accept && s_last && !ptr_at_end;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake decode and bank-swap / release decisions.
    always_comb begin
        state_nxt  = state;
        s_ready    = (state == FILL);
        swap       = 1'b0;
        release_rd = 1'b0;
        case (state)
            FILL: begin
                if (complete) begin
                    // A consumer releasing on the completing cycle frees the read bank at once.
                    if (!frame_valid || frame_done) begin
                        swap = 1'b1;
                    end else begin
                        state_nxt = HOLD;
                    end
                end else if (frame_done && frame_valid) begin
                    release_rd = 1'b1;
                end
            end
            HOLD: begin
                if (frame_done) begin
                    swap      = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Write pointer, bank pointer, frame bookkeeping and sticky framing error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            wbank       <= 1'b0;
            frame_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
            err_frame   <= 1'b0;
        end else begin
            frame_start <= swap;
            if (accept) begin
                // A short frame is dropped by restarting at pixel 0; a full frame wraps naturally.
                wr_ptr <= short_frame ? '0 : wr_ptr + ADDR_W'(1);
            end
            if (swap) begin
                wbank       <= ~wbank;
                frame_valid <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end else if (release_rd) begin
                frame_valid <= 1'b0;
            end
            if (short_frame || (complete && !s_last)) begin
                err_frame <= 1'b1;
            end
        end
    end

    // Host pixel writes into the bank currently being filled; contents are never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wbank) begin
                bank1[wr_ptr] <= s_data;
            end else begin
                bank0[wr_ptr] <= s_data;
            end
        end
    end

    // Registered read port, using the read bank selected at the sampling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rbank ? bank1[rd_addr] : bank0[rd_addr];
        end
    end

endmodule

// File: tb/tb_image_ingest.sv
// tb/tb_image_ingest.sv - self-checking bench for image_ingest against a frame-level reference model
module tb_image_ingest;

    localparam int N = 256;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       s_last = 1'b0;
    logic       frame_done = 1'b0;
    logic [7:0] rd_addr = 8'd0;
    logic       s_ready;
    logic       frame_valid;
    logic       frame_start;
    logic [7:0] rd_data;
    logic [7:0] frame_count;
    logic       err_frame;

    image_ingest #(.PIX_W(8), .ADDR_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .frame_valid (frame_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_count (frame_count),
        .err_frame   (err_frame)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frames as whole arrays, the host frame under construction as a queue.
    logic [7:0] m_cur  [N];
    logic [7:0] m_pend [N];
    logic [7:0] m_buf  [$];
    bit         m_known;
    bit         m_valid;
    bit         m_hold;
    bit         m_err;
    bit         m_start;
    int         m_count;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp1;
        logic [7:0] exp2;
    } rd_vec_t;

    rd_vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_known = 0;
        m_valid = 0;
        m_hold  = 0;
        m_err   = 0;
        m_start = 0;
        m_count = 0;
    endtask

    task automatic present_buf();
        for (int i = 0; i < N; i++) m_cur[i] = m_buf[i];
        m_known = 1;
        m_valid = 1;
        m_start = 1;
        m_count = (m_count + 1) % 256;
    endtask

    task automatic present_pend();
        for (int i = 0; i < N; i++) m_cur[i] = m_pend[i];
        m_known = 1;
        m_valid = 1;
        m_start = 1;
        m_count = (m_count + 1) % 256;
    endtask

    // Called at a negedge with inputs driven: advance model and DUT one cycle, then compare.
    task automatic tick();
        bit         acc;
        bit         completes;
        bit         hold_before;
        bit         known;
        logic [7:0] exp_rd;
        check("s_ready", s_ready, !m_hold);
        hold_before = m_hold;
        acc         = s_valid && !m_hold;
        completes   = acc && (m_buf.size() == N - 1);
        exp_rd      = m_cur[rd_addr];
        known       = m_known;
        m_start     = 0;
        if (acc) begin
            m_buf.push_back(s_data);
            if (completes) begin
                if (!s_last) m_err = 1;
                if (!m_valid || frame_done) begin
                    present_buf();
                end else begin
                    for (int i = 0; i < N; i++) m_pend[i] = m_buf[i];
                    m_hold = 1;
                end
                m_buf.delete();
            end else if (s_last) begin
                m_err = 1;
                m_buf.delete();
            end
        end
        if (hold_before && frame_done) begin
            present_pend();
            m_hold = 0;
        end else if (!hold_before && !completes && frame_done && m_valid) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check("frame_valid", frame_valid, m_valid);
        check("frame_start", frame_start, m_start);
        check("frame_count", frame_count, m_count);
        check("err_frame", err_frame, m_err);
        if (known) check("rd_data", rd_data, exp_rd);
    endtask

    task automatic idle(input int cycles);
        s_valid    = 0;
        s_last     = 0;
        frame_done = 0;
        for (int i = 0; i < cycles; i++) begin
            rd_addr = 8'($urandom);
            tick();
        end
    endtask

    // kind 0: pixel = index, kind 1: pixel = 255 - index, otherwise random.
    task automatic send_frame(input int kind, input int len, input bit last_flag, input bit done_on_last);
        for (int i = 0; i < len; i++) begin
            s_valid    = 1;
            s_data     = (kind == 0) ? 8'(i) : (kind == 1) ? 8'(255 - i) : 8'($urandom);
            s_last     = last_flag && (i == len - 1);
            frame_done = done_on_last && (i == len - 1);
            rd_addr    = 8'($urandom);
            tick();
        end
        s_valid    = 0;
        s_last     = 0;
        frame_done = 0;
    endtask

    task automatic apply_reset();
        s_valid    = 0;
        s_last     = 0;
        frame_done = 0;
        rst_n      = 1'b0;
        #1;
        model_reset();
        check("rst_s_ready", s_ready, 1);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_err_frame", err_frame, 0);
        check("rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{addr: 8'h00, exp1: 8'h00, exp2: 8'hFF};
        tbl[1] = '{addr: 8'h7F, exp1: 8'h7F, exp2: 8'h80};
        tbl[2] = '{addr: 8'hFF, exp1: 8'hFF, exp2: 8'h00};
        tbl[3] = '{addr: 8'h10, exp1: 8'h10, exp2: 8'hEF};

        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        apply_reset();
        idle(2);

        // Frame 1: ramp, properly terminated.
        send_frame(0, N, 1, 0);
        check("f1_start", frame_start, 1);
        check("f1_count", frame_count, 1);
        check("f1_err", err_frame, 0);
        for (int k = 0; k < 4; k++) begin
            rd_addr = tbl[k].addr;
            tick();
            check("f1_rd_tbl", rd_data, tbl[k].exp1);
        end

        // Frame 2 while frame 1 is unreleased: block stalls, read bank unchanged.
        send_frame(1, N, 1, 0);
        check("hold_s_ready", s_ready, 0);
        check("hold_count", frame_count, 1);
        for (int k = 0; k < 4; k++) begin
            rd_addr = tbl[k].addr;
            tick();
            check("hold_rd_tbl", rd_data, tbl[k].exp1);
        end
        frame_done = 1;
        tick();
        frame_done = 0;
        check("release_s_ready", s_ready, 1);
        check("release_start", frame_start, 1);
        check("release_count", frame_count, 2);
        for (int k = 0; k < 4; k++) begin
            rd_addr = tbl[k].addr;
            tick();
            check("f2_rd_tbl", rd_data, tbl[k].exp2);
        end

        // Completion coinciding with frame_done: no stall, single pulse.
        send_frame(2, N, 1, 1);
        check("simul_s_ready", s_ready, 1);
        check("simul_valid", frame_valid, 1);
        check("simul_count", frame_count, 3);
        idle(1);
        check("simul_single_pulse", frame_start, 0);

        // Reset in the middle of a frame, then a clean frame.
        send_frame(2, 100, 0, 0);
        apply_reset();
        send_frame(2, N, 1, 0);
        check("post_rst_count", frame_count, 1);
        check("post_rst_err", err_frame, 0);

        // Full-length frame without s_last: presented, error flagged.
        send_frame(2, N, 0, 1);
        check("nolast_count", frame_count, 2);
        check("nolast_err", err_frame, 1);
        check("nolast_start", frame_start, 1);

        // Short frame (s_last on beat 10) is dropped, next frame accepted.
        apply_reset();
        send_frame(2, 11, 1, 0);
        idle(1);
        check("short_err", err_frame, 1);
        check("short_count", frame_count, 0);
        check("short_valid", frame_valid, 0);
        send_frame(0, N, 1, 0);
        check("after_short_count", frame_count, 1);
        check("after_short_start", frame_start, 1);

        // 256 back-to-back frames at full rate: counter wraps to 0.
        apply_reset();
        for (int f = 0; f < 256; f++) send_frame(2, N, 1, 1);
        check("wrap_count", frame_count, 0);
        check("wrap_valid", frame_valid, 1);

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            s_valid    = ($urandom_range(3) != 0);
            s_data     = 8'($urandom);
            s_last     = (m_buf.size() == N - 1) ? ($urandom_range(4) != 0) : ($urandom_range(299) == 0);
            frame_done = ($urandom_range(99) == 0);
            rd_addr    = 8'($urandom);
            tick();
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/image_ingest.md
# image_ingest

Host-side image writer feeding the CNN forward pipeline. It accepts a pixel stream over a valid/ready handshake and assembles 256-pixel (16x16) frames into a ping-pong pair of image banks. It presents each completed frame to the convolution front end through an addressed, registered read port. While the convolution front end consumes one frame, the host streams the next one.

## Interface
Parameters:
- PIX_W, 8, pixel width in bits
- ADDR_W, 8, pixel address width; frame depth is 2^ADDR_W = 256

Ports (one clock, `clk`; reset is asynchronous and active-low, `rst_n`):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  host pixel beat valid
- s_ready  out  1  block accepts beat this cycle
- s_data  in  PIX_W  pixel value
- s_last  in  1  host marks final pixel of frame
- frame_valid  out  1  read bank holds a complete frame
- frame_start  out  1  one-cycle pulse: new frame presented on read bank
- frame_done  in  1  consumer releases current read frame (pulse)
- rd_addr  in  ADDR_W  pixel address into read bank
- rd_data  out  PIX_W  pixel at rd_addr, one-cycle latency
- frame_count  out  8  completed frames presented, wraps 255→0
- err_frame  out  1  sticky framing error

## Operation
- Two banks, 2^ADDR_W x PIX_W each. Pointers: wbank (host writes) and rbank (consumer reads), always different. Bank contents are not reset.
- Write FSM, states FILL and HOLD:
  - FILL: s_ready=1. An accepted beat (s_valid & s_ready) writes s_data to wbank[wr_ptr], then wr_ptr increments.
  - Short frame: s_last on a beat with wr_ptr<255. Set err_frame, write the beat, reset wr_ptr to 0, and discard the frame. Stay in FILL.
  - Beat at wr_ptr=255 completes the frame whether or not s_last is set. If s_last=0, err_frame is set; the frame is still valid. wr_ptr wraps to 0.
  - On completion with frame_valid=0, or with frame_done asserted the same cycle: swap wbank/rbank, set frame_valid=1, pulse frame_start, increment frame_count, and stay in FILL.
  - On completion with frame_valid=1 and no frame_done: go to HOLD. s_ready=0.
  - HOLD: on frame_done, swap banks, pulse frame_start, increment frame_count, and return to FILL. frame_valid stays 1 throughout.
- Read side:
  - frame_done with frame_valid=1 and the write FSM in FILL with no completion this cycle clears frame_valid.
  - frame_done with frame_valid=0 is ignored.
- rd_data is registered from rbank[rd_addr]. It uses the rbank selection in effect at the sampling edge.
- err_frame clears only on reset.

## Timing
- Reset values: s_ready=1 (FILL), wr_ptr=0, wbank=0, rbank=1, frame_valid=0, frame_start=0, frame_count=0, err_frame=0, rd_data=0.
- s_ready is a combinational decode of FSM state, with no dependence on s_valid.
- Completing beat accepted at edge t:
  - frame_valid=1 and frame_start=1 after t.
  - rd_addr sampled at the next edge; rd_data valid after that, i.e. first pixel 2 cycles after the last beat.
- Simultaneous completion and frame_done:
  - Swap occurs, no HOLD, no frame_valid gap, single frame_start pulse.
- In HOLD, frame_done at edge t:
  - s_ready=1 after t; swap and frame_start after t.
- Full-rate streaming (one beat/cycle) is sustained as long as the consumer releases each frame before the next one completes.
- Reset assertion mid-frame: all state returns to reset values asynchronously and the partial frame is lost. Release is synchronised by the standard reset bridge upstream.

## Test plan
- Reset, stream pixels 0..255 (s_last on beat 255) → frame_start at t+1, frame_count=1; read addr 0x00/0x7F/0xFF returns 0x00/0x7F/0xFF one cycle later; err_frame=0.
- Second frame (values 255-i) streamed with frame 1 unreleased → s_ready=0 after beat 255. frame_done → s_ready=1 and frame_start next cycle; addr 0x00 reads 0xFF.
- Frame completion on the same cycle as frame_done → no HOLD, s_ready stays 1, frame_valid never drops, frame_count increments by exactly 1.
- s_last on beat 10 → err_frame=1, no frame_start, frame_count unchanged; following 256-beat frame is accepted normally.
- 256 beats with s_last=0 → frame presented, err_frame=1; 256 frames back-to-back → frame_count wraps to 0.
- rst_n pulsed low at beat 100 → s_ready=1, frame_valid=0, frame_count=0, rd_data=0 immediately; a new full frame then completes normally.
